// File: rtl/lcd_bus_receiver_pkg.sv
// Shared constants, bus payload type, FSM states and AC stepping for the LCD bus receiver.
// Command masks identify the highest set bit of an HD44780 instruction byte.
package lcd_rx_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned AC_W      = 7;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned BUF_DEPTH = 32;

  localparam logic [DATA_W-1:0] CMD_CLEAR = 8'h01;
  localparam logic [DATA_W-1:0] CMD_HOME  = 8'h02;
  localparam logic [DATA_W-1:0] CMD_ENTRY = 8'h04;
  localparam logic [DATA_W-1:0] CMD_DISP  = 8'h08;
  localparam logic [DATA_W-1:0] CMD_SHIFT = 8'h10;
  localparam logic [DATA_W-1:0] CMD_FUNC  = 8'h20;
  localparam logic [DATA_W-1:0] CMD_CGRAM = 8'h40;
  localparam logic [DATA_W-1:0] CMD_DDRAM = 8'h80;

  localparam logic [DATA_W-1:0] CHR_SPACE  = 8'h20;
  localparam logic [AC_W-1:0]   LINE2_BASE = 7'h40;
  localparam logic [AC_W-1:0]   LINE_END   = 7'h27;
  localparam logic [AC_W-1:0]   LINE2_END  = 7'h67;

  typedef struct packed {
    logic              rw;
    logic              rs;
    logic [DATA_W-1:0] data;
  } lcd_xfer_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_BUSY   = 2'd2
  } state_e;

  // DDRAM address step: each line ends at xx27 and wraps to the other line's start.
  function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac, input logic up);
    logic [AC_W-1:0] nxt;
    if (up) begin
      if (ac == LINE_END)       nxt = LINE2_BASE;
      else if (ac == LINE2_END) nxt = '0;
      else                      nxt = ac + AC_W'(1);
    end else begin
      if (ac == LINE2_BASE)     nxt = LINE_END;
      else if (ac == '0)        nxt = LINE2_END;
      else                      nxt = ac - AC_W'(1);
    end
    return nxt;
  endfunction

  function automatic logic ac_visible(input logic [AC_W-1:0] ac);
    return (ac[5:4] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] ac_index(input logic [AC_W-1:0] ac);
    return {ac[6], ac[3:0]};
  endfunction

endpackage

// File: rtl/lcd_bus_receiver_if.sv
// HD44780 8-bit parallel bus. LCD_RX_BUSYFLAG_EN adds the busy-flag readback
// driver (LCD_DATA_OUT / LCD_DATA_OE) from the receiver side.
interface lcd_bus_if;
  logic [7:0] LCD_DATA;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
`ifdef LCD_RX_BUSYFLAG_EN
  logic [7:0] LCD_DATA_OUT;
  logic       LCD_DATA_OE;

  modport master (output LCD_DATA, LCD_RS, LCD_RW, LCD_EN,
                  input  LCD_DATA_OUT, LCD_DATA_OE);
  modport slave  (input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN,
                  output LCD_DATA_OUT, LCD_DATA_OE);
`else
  modport master (output LCD_DATA, LCD_RS, LCD_RW, LCD_EN);
  modport slave  (input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN);
`endif
endinterface

// File: rtl/lcd_bus_receiver_sync.sv
// Multi-stage synchronizer for the LCD bus plus EN falling-edge detector.
// The synced EN level is exported only when LCD_RX_BUSYFLAG_EN is defined.
module lcd_bus_sync
  import lcd_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rs_i,
  input  logic              rw_i,
  input  logic              en_i,
  output lcd_xfer_t         xfer_o,
`ifdef LCD_RX_BUSYFLAG_EN
  output logic              en_o,
`endif
  output logic              fall_c
);

  localparam int unsigned SAMPLE_W = DATA_W + 3;
  localparam int unsigned LAST     = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0][SAMPLE_W-1:0] stage_q, stage_d;
  logic                                 en_prev_q, en_prev_d;
  logic                                 en_s;

  // EN, RW, RS and DATA travel through the same depth so they stay aligned.
  always_comb begin
    stage_d    = '0;
    stage_d[0] = {en_i, rw_i, rs_i, data_i};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    en_prev_d = en_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= '0;
      en_prev_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      en_prev_q <= en_prev_d;
    end
  end

  assign en_s   = stage_q[LAST][SAMPLE_W-1];
  assign xfer_o = lcd_xfer_t'(stage_q[LAST][SAMPLE_W-2:0]);
  assign fall_c = en_prev_q & ~en_s;
`ifdef LCD_RX_BUSYFLAG_EN
  assign en_o   = en_s;
`endif

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-compatible bus responder mirroring a 2x16 display into a shadow buffer.
// Optional LCD_RX_BUSYFLAG_EN answers RS=0 reads with {busy, AC} on LCD_DATA_OUT.
module lcd_bus_receiver
  import lcd_rx_pkg::*;
#(
  parameter int unsigned BUSY_CYC    = 2000,
  parameter int unsigned CLR_CYC     = 82000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  lcd_bus_if.slave          lcd,
  input  logic [IDX_W-1:0]  iRD_ADDR,
  output logic [DATA_W-1:0] oRD_DATA,
  output logic [AC_W-1:0]   oAC,
  output logic              oDISP_ON,
  output logic              oCURSOR_ON,
  output logic              oBUSY,
  output logic              oCMD_VALID,
  output logic [DATA_W-1:0] oCMD,
  output logic              oCHAR_WR,
  output logic              oFRAME,
  output logic              oOVERRUN,
  output logic              oPROTO_ERR
);

  localparam int unsigned MAX_CYC = (CLR_CYC > BUSY_CYC) ? CLR_CYC : BUSY_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  lcd_xfer_t s_xfer;
  logic      s_fall_c;
  logic      bf_rd_c;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, limit_c;
  lcd_xfer_t          xfer_q, xfer_d;
  logic [AC_W-1:0]    ac_q, ac_d;
  logic               inc_q, inc_d;
  logic               disp_q, disp_d;
  logic               cur_q, cur_d;
  logic [DATA_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0]  buf_q [BUF_DEPTH];
  logic [DATA_W-1:0]  buf_d [BUF_DEPTH];
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               busy_q, busy_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               char_wr_q, char_wr_d;
  logic               frame_q, frame_d;
  logic               overrun_q, overrun_d;
  logic               proto_q, proto_d;
  logic [IDX_W-1:0]   wr_idx_c;
  logic               long_c;

`ifdef LCD_RX_BUSYFLAG_EN
  logic               s_en;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               oe_q, oe_d;
`endif

  lcd_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (iCLK),
    .rst_n  (iRST_N),
    .data_i (lcd.LCD_DATA),
    .rs_i   (lcd.LCD_RS),
    .rw_i   (lcd.LCD_RW),
    .en_i   (lcd.LCD_EN),
    .xfer_o (s_xfer),
`ifdef LCD_RX_BUSYFLAG_EN
    .en_o   (s_en),
`endif
    .fall_c (s_fall_c)
  );

  // Clear Display and Return Home get the long busy window.
  assign long_c  = ~xfer_q.rs && (xfer_q.data[7:2] == 6'd0) && (xfer_q.data[1:0] != 2'd0);
  assign limit_c = long_c ? CNT_W'(CLR_CYC - 1) : CNT_W'(BUSY_CYC - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xfer_d      = xfer_q;
    ac_d        = ac_q;
    inc_d       = inc_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    cmd_d       = cmd_q;
    buf_d       = buf_q;
    cmd_valid_d = 1'b0;
    char_wr_d   = 1'b0;
    frame_d     = 1'b0;
    overrun_d   = 1'b0;
    proto_d     = 1'b0;
    wr_idx_c    = ac_index(ac_q);
`ifdef LCD_RX_BUSYFLAG_EN
    bf_rd_c     = ~s_xfer.rs;
`else
    bf_rd_c     = 1'b0;
`endif

    // Reads never enter the FSM; writes while busy are dropped.
    if (s_fall_c) begin
      if (s_xfer.rw) begin
        proto_d = ~bf_rd_c;
      end else if (state_q != ST_IDLE) begin
        overrun_d = 1'b1;
      end else begin
        state_d = ST_DECODE;
        xfer_d  = s_xfer;
      end
    end

    case (state_q)
      ST_DECODE: begin
        state_d = ST_BUSY;
        cnt_d   = '0;
        if (xfer_q.rs) begin
          if (ac_visible(ac_q)) begin
            buf_d[wr_idx_c] = xfer_q.data;
            char_wr_d       = 1'b1;
            frame_d         = (wr_idx_c == IDX_W'(BUF_DEPTH - 1));
          end
          ac_d = ac_step(ac_q, inc_q);
        end else begin
          cmd_valid_d = 1'b1;
          cmd_d       = xfer_q.data;
          if ((xfer_q.data & CMD_DDRAM) != '0) begin
            ac_d = xfer_q.data[AC_W-1:0];
          end else if ((xfer_q.data & (CMD_CGRAM | CMD_FUNC)) != '0) begin
            ac_d = ac_q;
          end else if ((xfer_q.data & CMD_SHIFT) != '0) begin
            if (!xfer_q.data[3]) ac_d = ac_step(ac_q, xfer_q.data[2]);
          end else if ((xfer_q.data & CMD_DISP) != '0) begin
            disp_d = xfer_q.data[2];
            cur_d  = xfer_q.data[1];
          end else if ((xfer_q.data & CMD_ENTRY) != '0) begin
            inc_d = xfer_q.data[1];
          end else if ((xfer_q.data & CMD_HOME) != '0) begin
            ac_d = '0;
          end else if ((xfer_q.data & CMD_CLEAR) != '0) begin
            for (int i = 0; i < BUF_DEPTH; i++) buf_d[i] = CHR_SPACE;
            ac_d  = '0;
            inc_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == limit_c) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase

    busy_d    = (state_d != ST_IDLE);
    rd_data_d = buf_q[iRD_ADDR];
  end

`ifdef LCD_RX_BUSYFLAG_EN
  always_comb begin
    oe_d   = s_xfer.rw & ~s_xfer.rs & s_en;
    dout_d = {busy_q, ac_q};
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      oe_q   <= oe_d;
      dout_q <= dout_d;
    end
  end

  assign lcd.LCD_DATA_OE  = oe_q;
  assign lcd.LCD_DATA_OUT = dout_q;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      xfer_q      <= '0;
      ac_q        <= '0;
      inc_q       <= 1'b1;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      cmd_q       <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= CHR_SPACE;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      char_wr_q   <= 1'b0;
      frame_q     <= 1'b0;
      overrun_q   <= 1'b0;
      proto_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xfer_q      <= xfer_d;
      ac_q        <= ac_d;
      inc_q       <= inc_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      cmd_q       <= cmd_d;
      buf_q       <= buf_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      char_wr_q   <= char_wr_d;
      frame_q     <= frame_d;
      overrun_q   <= overrun_d;
      proto_q     <= proto_d;
    end
  end

  assign oRD_DATA   = rd_data_q;
  assign oAC        = ac_q;
  assign oDISP_ON   = disp_q;
  assign oCURSOR_ON = cur_q;
  assign oBUSY      = busy_q;
  assign oCMD_VALID = cmd_valid_q;
  assign oCMD       = cmd_q;
  assign oCHAR_WR   = char_wr_q;
  assign oFRAME     = frame_q;
  assign oOVERRUN   = overrun_q;
  assign oPROTO_ERR = proto_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Randomized bench for lcd_bus_receiver against a transaction-level display model.
module tb_lcd_bus_receiver;
  import lcd_rx_pkg::*;

  localparam int unsigned BUSY = 12;
  localparam int unsigned CLR  = 40;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_if bus();

  logic [4:0] rd_addr;
  logic [7:0] rd_data, cmd;
  logic [6:0] ac;
  logic       disp_on, cursor_on, busy, cmd_valid, char_wr, frame, overrun, proto_err;

  lcd_bus_receiver #(
    .BUSY_CYC    (BUSY),
    .CLR_CYC     (CLR),
    .SYNC_STAGES (SYNC)
  ) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .lcd        (bus),
    .iRD_ADDR   (rd_addr),
    .oRD_DATA   (rd_data),
    .oAC        (ac),
    .oDISP_ON   (disp_on),
    .oCURSOR_ON (cursor_on),
    .oBUSY      (busy),
    .oCMD_VALID (cmd_valid),
    .oCMD       (cmd),
    .oCHAR_WR   (char_wr),
    .oFRAME     (frame),
    .oOVERRUN   (overrun),
    .oPROTO_ERR (proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitors: pulse counters and busy-window length.
  int n_char = 0, n_frame = 0, n_pair = 0, n_cmdv = 0, n_ovr = 0, n_proto = 0;
  int busy_run = 0, busy_len = 0;
  always @(negedge clk) begin
    if (char_wr)           n_char++;
    if (frame)             n_frame++;
    if (frame && char_wr)  n_pair++;
    if (cmd_valid)         n_cmdv++;
    if (overrun)           n_ovr++;
    if (proto_err)         n_proto++;
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Reference model of the display controller.
  int         m_ac;
  bit         m_inc, m_disp, m_cur;
  logic [7:0] m_cmd;
  logic [7:0] m_buf [32];
  int e_char = 0, e_frame = 0, e_cmdv = 0, e_ovr = 0, e_proto = 0, e_len = 0;

  function automatic int step(input int a, input bit up);
    if (up) begin
      if (a == 39)  return 64;
      if (a == 103) return 0;
      return (a + 1) % 128;
    end
    if (a == 64) return 39;
    if (a == 0)  return 103;
    return (a + 127) % 128;
  endfunction

  task automatic model_reset();
    m_ac = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_cmd = 8'h00;
    for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
  endtask

  task automatic model_xfer(input bit rs, input logic [7:0] d);
    int hb, idx;
    if (rs) begin
      if ((m_ac / 16) % 4 == 0) begin
        idx = ((m_ac >= 64) ? 16 : 0) + (m_ac % 16);
        m_buf[idx] = d;
        e_char++;
        if (idx == 31) e_frame++;
      end
      m_ac  = step(m_ac, m_inc);
      e_len = BUSY + 1;
    end else begin
      e_cmdv++;
      m_cmd = d;
      hb = -1;
      for (int b = 7; b >= 0; b--) if (hb < 0 && d[b]) hb = b;
      case (hb)
        7: m_ac = int'(d) % 128;
        4: if (!d[3]) m_ac = step(m_ac, d[2]);
        3: begin m_disp = d[2]; m_cur = d[1]; end
        2: m_inc = d[1];
        1: m_ac = 0;
        0: begin
          for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
          m_ac = 0; m_inc = 1;
        end
        default: ;
      endcase
      e_len = (hb == 0 || hb == 1) ? CLR + 1 : BUSY + 1;
    end
  endtask

  task automatic bus_pulse(input bit rs, input bit rw, input logic [7:0] d);
    @(negedge clk);
    bus.LCD_DATA = d; bus.LCD_RS = rs; bus.LCD_RW = rw; bus.LCD_EN = 1'b1;
    repeat (4) @(negedge clk);
`ifdef LCD_RX_BUSYFLAG_EN
    if (rw && !rs) begin
      chk("bf_oe", bus.LCD_DATA_OE, 1);
      chk("bf_out", bus.LCD_DATA_OUT, {1'b0, 7'(m_ac)});
    end
`endif
    bus.LCD_EN = 1'b0;
    repeat (4) @(negedge clk);
    bus.LCD_RW = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy) chk("busy_timeout", busy, 0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ac"},     ac, m_ac);
    chk({tag, ".disp"},   disp_on, m_disp);
    chk({tag, ".cursor"}, cursor_on, m_cur);
    chk({tag, ".cmd"},    cmd, m_cmd);
    chk({tag, ".nchar"},  n_char, e_char);
    chk({tag, ".nframe"}, n_frame, e_frame);
    chk({tag, ".npair"},  n_pair, e_frame);
    chk({tag, ".ncmdv"},  n_cmdv, e_cmdv);
    chk({tag, ".novr"},   n_ovr, e_ovr);
    chk({tag, ".nproto"}, n_proto, e_proto);
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      rd_addr = 5'(i);
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, i), rd_data, m_buf[i]);
    end
  endtask

  task automatic wr(input bit rs, input logic [7:0] d, input string tag);
    bus_pulse(rs, 1'b0, d);
    model_xfer(rs, d);
    wait_idle(CLR + 40);
    @(negedge clk);
    chk({tag, ".busylen"}, busy_len, e_len);
    check_state(tag);
  endtask

  task automatic rd(input bit rs, input string tag);
    bus_pulse(rs, 1'b1, 8'($urandom));
`ifdef LCD_RX_BUSYFLAG_EN
    if (rs) e_proto++;
`else
    e_proto++;
`endif
    repeat (3) @(negedge clk);
    chk({tag, ".busy"}, busy, 0);
    check_state(tag);
  endtask

  logic [7:0] hello [5];
  logic [7:0] rc;
  int         cls;

  initial begin
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
    bus.LCD_DATA = 8'h00; bus.LCD_RS = 1'b0; bus.LCD_RW = 1'b0; bus.LCD_EN = 1'b0;
    rd_addr = 5'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst.ac", ac, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rd_data", rd_data, 0);
    chk("rst.disp", disp_on, 0);
    chk("rst.pulses", {cmd_valid, char_wr, frame, overrun, proto_err}, 0);
    rst_n = 1'b1;
    check_buf("rst.buf");

    // Init sequence and HELLO.
    wr(0, 8'h38, "init38"); wr(0, 8'h0C, "init0c"); wr(0, 8'h01, "init01");
    wr(0, 8'h06, "init06"); wr(0, 8'h80, "init80");
    for (int i = 0; i < 5; i++) wr(1, hello[i], "hello");
    chk("hello.ac", ac, 7'h05);
    chk("hello.disp", disp_on, 1);
    chk("hello.cursor", cursor_on, 0);
    chk("hello.chars", n_char, 5);
    check_buf("hello.buf");

    // Line 2, direct addressing, wrap from 0x27 and frame at index 31.
    wr(0, 8'hC0, "l2cmd"); wr(1, 8'h41, "l2dat");
    chk("l2.ac", ac, 7'h41);
    wr(0, 8'h8F, "c15cmd"); wr(1, 8'h5A, "c15dat");
    wr(0, 8'hA7, "wrapcmd"); wr(1, 8'h78, "wrapd0");
    chk("wrap.ac", ac, 7'h40);
    wr(1, 8'h79, "wrapd1");
    chk("wrap.ac2", ac, 7'h41);
    wr(0, 8'hCF, "framecmd"); wr(1, 8'h21, "framedat");
    chk("frame.count", n_frame, 1);
    check_buf("dir.buf");

    // Fill, then clear with an overrunning write in its busy window.
    wr(0, 8'h80, "fill1");
    for (int i = 0; i < 16; i++) wr(1, 8'($urandom_range(33, 126)), "fill");
    wr(0, 8'hC0, "fill2");
    for (int i = 0; i < 16; i++) wr(1, 8'($urandom_range(33, 126)), "fill");
    check_buf("fill.buf");
    bus_pulse(0, 1'b0, 8'h01);
    model_xfer(0, 8'h01);
    bus_pulse(1, 1'b0, 8'h41);
    e_ovr++;
    wait_idle(CLR + 40);
    @(negedge clk);
    chk("clear.busylen", busy_len, CLR + 1);
    check_state("clear");
    check_buf("clear.buf");

    rd(0, "rd_cmd");
    rd(1, "rd_dat");

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      cls = $urandom_range(0, 9);
      if (cls <= 4) begin
        wr(1, 8'($urandom), "rnd_dat");
      end else if (cls <= 8) begin
        cls = $urandom_range(0, 8);
        if (cls == 8) rc = 8'h00;
        else rc = 8'((1 << cls) | ($urandom & ((1 << cls) - 1)));
        wr(0, rc, "rnd_cmd");
      end else begin
        rd(1'($urandom_range(0, 1)), "rnd_rd");
      end
      if (n % 16 == 15) check_buf("rnd.buf");
    end

    // Reset in the middle of a busy window.
    wr(0, 8'h85, "prerst");
    bus_pulse(1, 1'b0, 8'h33);
    model_xfer(1, 8'h33);
    chk("prerst.busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.ac", ac, 0);
    chk("midrst.rd_data", rd_data, 0);
    model_reset();

    // EN already high when reset releases: its fall is a normal transfer.
    bus.LCD_DATA = 8'h51; bus.LCD_RS = 1'b1; bus.LCD_RW = 1'b0; bus.LCD_EN = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    bus.LCD_EN = 1'b0;
    model_xfer(1, 8'h51);
    repeat (4) @(negedge clk);
    wait_idle(CLR + 40);
    @(negedge clk);
    chk("enrel.busylen", busy_len, e_len);
    check_state("enrel");
    check_buf("enrel.buf");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
